// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/RAM interface types, plus the responder's latency and request-key types.
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef logic [31:0] word_t;

    localparam int RAM_LAT_MAX = 15;

    typedef logic [$clog2(RAM_LAT_MAX+1)-1:0] lat_t;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [29:0] widx;
    } ramkey_t;
endpackage

// File: rtl/ram_array.sv
// ram_array: DEPTH x 32 storage with a synchronous write port and a registered read port.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 16384,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  word_t         wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output word_t         rdata
);
    word_t mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge CLK) begin
        if (!nRST) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM model answering ramREN/ramWEN with the
// FREE/BUSY/ACCESS/ERROR handshake after LAT programmable wait cycles.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT = 2,
    parameter int DEPTH = 16384,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);
    ramstate_t state, state_n;
    ramkey_t   key, key_n, key_in;
    lat_t      cnt, cnt_n;
    logic      req, illegal, start, tick, acc;

    assign req     = ramREN | ramWEN;
    assign key_in  = {ramREN, ramWEN, ramaddr[31:2]};
    assign illegal = (ramREN & ramWEN) | (ramaddr[31:2] >= 30'(DEPTH));
    // A new transaction begins from any state except an unchanged request in BUSY.
    assign start   = req & ((state != BUSY) | (key_in != key));
    assign tick    = req & (state == BUSY) & (key_in == key);
    assign acc     = (start & ~illegal & (LAT == 0)) | (tick & (cnt == lat_t'(1)));

    always_comb begin
        state_n = !req ? FREE
                : start ? (illegal ? ERROR : (LAT == 0) ? ACCESS : BUSY)
                : (cnt == lat_t'(1)) ? ACCESS : BUSY;
        key_n   = (start & ~illegal) ? key_in : key;
        cnt_n   = (start & ~illegal) ? lat_t'(LAT) : tick ? cnt - lat_t'(1) : cnt;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= FREE;
            key   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            key   <= key_n;
            cnt   <= cnt_n;
        end
    end

    assign ramstate = state;

    ram_array #(.DEPTH(DEPTH)) u_mem (
        .CLK   (CLK),
        .nRST  (nRST),
        .we    (acc & ramWEN & nRST),
        .waddr (ramaddr[AW+1:2]),
        .wdata (ramstore),
        .re    (acc & ramREN),
        .raddr (ramaddr[AW+1:2]),
        .rdata (ramload)
    );
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed and random checks of two responders (LAT=2 and LAT=0)
// against a transaction-level memory model.
module tb_ram_responder;
    import cpu_types_pkg::*;

    logic        CLK = 0;
    logic        nRST;
    logic        ren [2];
    logic        wen [2];
    logic [31:0] addr [2];
    logic [31:0] store [2];
    logic [31:0] ld [2];
    logic [1:0]  st [2];

    int    total = 0;
    int    bad = 0;
    word_t mdl [int];
    word_t exp_ld [2];

    always #5 CLK = ~CLK;

    ram_responder #(.LAT(2)) dut_a (
        .CLK(CLK), .nRST(nRST), .ramREN(ren[0]), .ramWEN(wen[0]), .ramaddr(addr[0]),
        .ramstore(store[0]), .ramload(ld[0]), .ramstate(st[0])
    );

    ram_responder #(.LAT(0)) dut_b (
        .CLK(CLK), .nRST(nRST), .ramREN(ren[1]), .ramWEN(wen[1]), .ramaddr(addr[1]),
        .ramstore(store[1]), .ramload(ld[1]), .ramstate(st[1])
    );

    function automatic int lat_of(input int d);
        return d == 0 ? 2 : 0;
    endfunction

    function automatic int mkey(input int d, input logic [31:0] a);
        return (d << 24) | int'(a[25:2]);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int d);
        ren[d] = 0;
        wen[d] = 0;
    endtask

    // One complete transaction: LAT BUSY cycles, one ACCESS, then drop and expect FREE.
    task automatic xact(input int d, input logic r, input logic w, input logic [31:0] a, input word_t v);
        ren[d] = r;
        wen[d] = w;
        addr[d] = a;
        store[d] = v;
        for (int i = 0; i < lat_of(d); i++) begin
            step();
            chk("busy", {30'b0, st[d]}, {30'b0, BUSY});
        end
        step();
        chk("access", {30'b0, st[d]}, {30'b0, ACCESS});
        if (w) mdl[mkey(d, a)] = v;
        if (r) exp_ld[d] = mdl[mkey(d, a)];
        chk("load", ld[d], exp_ld[d]);
        idle(d);
        step();
        chk("free", {30'b0, st[d]}, {30'b0, FREE});
        chk("hold", ld[d], exp_ld[d]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        word_t v;
        for (int d = 0; d < 2; d++) begin
            idle(d);
            addr[d] = 0;
            store[d] = 0;
            exp_ld[d] = 0;
        end
        nRST = 0;
        step();
        step();
        nRST = 1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_state", {30'b0, st[d]}, {30'b0, FREE});
            chk("rst_load", ld[d], 32'h0);
        end

        xact(0, 0, 1, 32'h40, 32'hDEADBEEF);
        xact(0, 1, 0, 32'h40, 32'h0);

        xact(0, 0, 1, 32'h80, 32'h11112222);
        ren[0] = 1; wen[0] = 1; addr[0] = 32'h80; store[0] = 32'hFFFF0000;
        repeat (3) begin
            step();
            chk("err_both", {30'b0, st[0]}, {30'b0, ERROR});
        end
        idle(0);
        step();
        chk("err_free", {30'b0, st[0]}, {30'b0, FREE});
        xact(0, 1, 0, 32'h80, 32'h0);

        ren[0] = 1; addr[0] = 32'h0001_0000;
        step();
        chk("err_range", {30'b0, st[0]}, {30'b0, ERROR});
        addr[0] = 32'h40;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("err_legal_busy", {30'b0, st[0]}, {30'b0, BUSY});
        end
        step();
        chk("err_legal_acc", {30'b0, st[0]}, {30'b0, ACCESS});
        exp_ld[0] = mdl[mkey(0, 32'h40)];
        chk("err_legal_load", ld[0], exp_ld[0]);
        idle(0);
        step();

        xact(0, 0, 1, 32'h100, 32'hAAAA0001);
        wen[0] = 1; addr[0] = 32'h100; store[0] = 32'h5555;
        step();
        chk("abort_busy", {30'b0, st[0]}, {30'b0, BUSY});
        idle(0);
        step();
        chk("abort_free", {30'b0, st[0]}, {30'b0, FREE});
        xact(0, 1, 0, 32'h100, 32'h0);

        xact(0, 0, 1, 32'h200, 32'h2000_0200);
        xact(0, 0, 1, 32'h204, 32'h2000_0204);
        ren[0] = 1; addr[0] = 32'h200;
        step();
        chk("rst_busy0", {30'b0, st[0]}, {30'b0, BUSY});
        addr[0] = 32'h204;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("restart_busy", {30'b0, st[0]}, {30'b0, BUSY});
        end
        step();
        chk("restart_acc", {30'b0, st[0]}, {30'b0, ACCESS});
        exp_ld[0] = mdl[mkey(0, 32'h204)];
        chk("restart_load", ld[0], exp_ld[0]);
        idle(0);
        step();

        xact(0, 0, 1, 32'h300, 32'h0BADBEEF);
        xact(0, 1, 0, 32'h40, 32'h0);
        wen[0] = 1; addr[0] = 32'h300; store[0] = 32'hCAFEF00D;
        step();
        chk("midrst_busy", {30'b0, st[0]}, {30'b0, BUSY});
        nRST = 0;
        step();
        chk("midrst_free", {30'b0, st[0]}, {30'b0, FREE});
        chk("midrst_load", ld[0], 32'h0);
        exp_ld[0] = 0;
        exp_ld[1] = 0;
        nRST = 1;
        idle(0);
        step();
        xact(0, 1, 0, 32'h300, 32'h0);

        ren[0] = 1; addr[0] = 32'h40;
        repeat (2) begin
            for (int i = 0; i < 2; i++) begin
                step();
                chk("held_busy", {30'b0, st[0]}, {30'b0, BUSY});
            end
            step();
            chk("held_acc", {30'b0, st[0]}, {30'b0, ACCESS});
            exp_ld[0] = mdl[mkey(0, 32'h40)];
            chk("held_load", ld[0], exp_ld[0]);
        end
        idle(0);
        step();
        chk("held_free", {30'b0, st[0]}, {30'b0, FREE});

        for (int i = 0; i < 24; i++) begin
            a = 32'h1000 + ($urandom_range(0, 15) << 2);
            v = $urandom;
            if ($urandom_range(0, 1) == 1 && mdl.exists(mkey(0, a))) xact(0, 1, 0, a, 32'h0);
            else xact(0, 0, 1, a, v);
        end

        xact(1, 0, 1, 32'h0, 32'h12345678);
        xact(1, 1, 0, 32'h0, 32'h0);
        ren[1] = 1; addr[1] = 32'h0;
        repeat (3) begin
            step();
            chk("b_held_acc", {30'b0, st[1]}, {30'b0, ACCESS});
            chk("b_held_load", ld[1], 32'h12345678);
        end
        addr[1] = 32'h0001_0000;
        step();
        chk("b_err", {30'b0, st[1]}, {30'b0, ERROR});
        idle(1);
        step();
        chk("b_free", {30'b0, st[1]}, {30'b0, FREE});
        for (int i = 0; i < 12; i++) begin
            a = 32'h2000 + ($urandom_range(0, 7) << 2);
            v = $urandom;
            if ($urandom_range(0, 1) == 1 && mdl.exists(mkey(1, a))) xact(1, 1, 0, a, 32'h0);
            else xact(1, 0, 1, a, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
